// File: rtl/apb_i2c_pkg.sv
// Shared constants for the APB register interface of the I2C controller:
// register offsets, STATUS/IRQ bit positions and the bus FSM state type.
package apb_i2c_pkg;

    localparam logic [7:0] OFF_TXDATA   = 8'h00;
    localparam logic [7:0] OFF_RXDATA   = 8'h04;
    localparam logic [7:0] OFF_CONFIG   = 8'h08;
    localparam logic [7:0] OFF_TIMEOUT  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h14;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h18;

    localparam int STAT_W         = 4;
    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_EMPTY  = 1;
    localparam int STAT_RX_EMPTY  = 2;
    localparam int STAT_I2C_ERROR = 3;

    localparam int IRQ_W         = 3;
    localparam int IRQ_TX_EMPTY  = 0;
    localparam int IRQ_RX_AVAIL  = 1;
    localparam int IRQ_I2C_ERROR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_i2c_irq_ctrl.sv
// Interrupt block: edge detection on core status, sticky IRQ_STAT with
// write-one-to-clear, IRQ_EN mask and the combined interrupt line.
module apb_i2c_irq_ctrl
    import apb_i2c_pkg::*;
(
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             TX_EMPTY,
    input  logic             RX_EMPTY,
    input  logic             I2C_ERROR,
    input  logic             en_we,
    input  logic             stat_we,
    input  logic [IRQ_W-1:0] wdata,
    output logic [IRQ_W-1:0] irq_en,
    output logic [IRQ_W-1:0] irq_stat,
    output logic             IRQ
);

    logic             tx_empty_q;
    logic             rx_empty_q;
    logic             i2c_error_q;
    logic [IRQ_W-1:0] irq_set;
    logic [IRQ_W-1:0] stat_clr;

    always_comb begin
        irq_set                = '0;
        irq_set[IRQ_TX_EMPTY]  = TX_EMPTY & ~tx_empty_q;
        irq_set[IRQ_RX_AVAIL]  = ~RX_EMPTY & rx_empty_q;
        irq_set[IRQ_I2C_ERROR] = I2C_ERROR & ~i2c_error_q;
    end

    assign stat_clr = stat_we ? wdata : '0;

    // Set is OR-ed in after the clear so a same-cycle event is never lost.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_empty_q  <= 1'b0;
            rx_empty_q  <= 1'b0;
            i2c_error_q <= 1'b0;
            irq_en      <= '0;
            irq_stat    <= '0;
        end else begin
            tx_empty_q  <= TX_EMPTY;
            rx_empty_q  <= RX_EMPTY;
            i2c_error_q <= I2C_ERROR;
            if (en_we) begin
                irq_en <= wdata;
            end
            irq_stat <= (irq_stat & ~stat_clr) | irq_set;
        end
    end

    assign IRQ = |(irq_stat & irq_en);

endmodule

// File: rtl/apb_i2c_regif.sv
// APB slave front end of the I2C controller: bus FSM, register file, and
// TX push / RX pop with a bounded stall on full/empty FIFOs.
//  state  | meaning
//  IDLE   | no transfer in progress, waiting for a setup phase
//  SETUP  | transfer accepted, stall counter loaded
//  ACCESS | first access cycle; register accesses complete here
//  STALL  | FIFO access waiting for space/data or for the stall limit
module apb_i2c_regif
    import apb_i2c_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int CFG_W    = 14,
    parameter int WAIT_MAX = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [CFG_W-1:0]  CFG,
    output logic [CFG_W-1:0]  TIMEOUT,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_WR_EN,
    input  logic [DATA_W-1:0] RX_DATA,
    output logic              RX_RD_EN,
    input  logic              TX_FULL,
    input  logic              TX_EMPTY,
    input  logic              RX_EMPTY,
    input  logic              I2C_ERROR,
    output logic              IRQ
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    apb_state_t        state;
    apb_state_t        state_n;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CFG_W-1:0]  cfg_q;
    logic [CFG_W-1:0]  timeout_q;
    logic [IRQ_W-1:0]  irq_en;
    logic [IRQ_W-1:0]  irq_stat;
    logic [STAT_W-1:0] status;
    logic [DATA_W-1:0] rdata;

    logic hit_tx, hit_rx, hit_cfg, hit_to, hit_stat, hit_ien, hit_ist;
    logic req_err, fifo_tx, fifo_rx, fifo_blocked, stall_tc;
    logic in_xfer, xfer_done, xfer_ok;

    // Full-width compares also reject non-word-aligned addresses.
    assign hit_tx   = (PADDR == ADDR_W'(OFF_TXDATA));
    assign hit_rx   = (PADDR == ADDR_W'(OFF_RXDATA));
    assign hit_cfg  = (PADDR == ADDR_W'(OFF_CONFIG));
    assign hit_to   = (PADDR == ADDR_W'(OFF_TIMEOUT));
    assign hit_stat = (PADDR == ADDR_W'(OFF_STATUS));
    assign hit_ien  = (PADDR == ADDR_W'(OFF_IRQ_EN));
    assign hit_ist  = (PADDR == ADDR_W'(OFF_IRQ_STAT));

    assign req_err = !(hit_tx || hit_rx || hit_cfg || hit_to || hit_stat || hit_ien || hit_ist)
                   || (PWRITE && (hit_rx || hit_stat))
                   || (!PWRITE && hit_tx);

    assign fifo_tx      = hit_tx && PWRITE;
    assign fifo_rx      = hit_rx && !PWRITE;
    assign fifo_blocked = (fifo_tx && TX_FULL) || (fifo_rx && RX_EMPTY);
    assign stall_tc     = (stall_cnt == '0);

    assign in_xfer   = (state == ACCESS || state == STALL) && PSEL && PENABLE && !PRESET;
    assign xfer_done = in_xfer && (!fifo_blocked || stall_tc);
    assign xfer_ok   = xfer_done && !req_err && !fifo_blocked;

    assign PREADY   = xfer_done;
    assign PSLVERR  = xfer_done && !xfer_ok;
    assign TX_WR_EN = xfer_ok && fifo_tx;
    assign RX_RD_EN = xfer_ok && fifo_rx;
    assign TX_DATA  = PWDATA;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:          if (PSEL && !PENABLE) state_n = SETUP;
            SETUP:         state_n = ACCESS;
            ACCESS, STALL: state_n = (!PSEL || xfer_done) ? IDLE : STALL;
            default:       state_n = IDLE;
        endcase
    end

    // Down-counter: loaded in SETUP, terminal count forces an error completion.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            stall_cnt <= '0;
        end else if (state == SETUP) begin
            stall_cnt <= CNT_W'(WAIT_MAX);
        end else if (in_xfer && !xfer_done && !stall_tc) begin
            stall_cnt <= stall_cnt - 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cfg_q     <= '0;
            timeout_q <= '0;
        end else if (xfer_ok && PWRITE) begin
            if (hit_cfg) cfg_q     <= PWDATA[CFG_W-1:0];
            if (hit_to)  timeout_q <= PWDATA[CFG_W-1:0];
        end
    end

    assign CFG     = cfg_q;
    assign TIMEOUT = timeout_q;

    always_comb begin
        status                 = '0;
        status[STAT_TX_FULL]   = TX_FULL;
        status[STAT_TX_EMPTY]  = TX_EMPTY;
        status[STAT_RX_EMPTY]  = RX_EMPTY;
        status[STAT_I2C_ERROR] = I2C_ERROR;
    end

    always_comb begin
        rdata = '0;
        if (xfer_ok && !PWRITE) begin
            if (hit_rx)        rdata                = RX_DATA;
            else if (hit_cfg)  rdata[CFG_W-1:0]     = cfg_q;
            else if (hit_to)   rdata[CFG_W-1:0]     = timeout_q;
            else if (hit_stat) rdata[STAT_W-1:0]    = status;
            else if (hit_ien)  rdata[IRQ_W-1:0]     = irq_en;
            else if (hit_ist)  rdata[IRQ_W-1:0]     = irq_stat;
        end
    end

    assign PRDATA = rdata;

    apb_i2c_irq_ctrl u_irq_ctrl (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .TX_EMPTY  (TX_EMPTY),
        .RX_EMPTY  (RX_EMPTY),
        .I2C_ERROR (I2C_ERROR),
        .en_we     (xfer_ok && PWRITE && hit_ien),
        .stat_we   (xfer_ok && PWRITE && hit_ist),
        .wdata     (PWDATA[IRQ_W-1:0]),
        .irq_en    (irq_en),
        .irq_stat  (irq_stat),
        .IRQ       (IRQ)
    );

endmodule

// File: doc/apb_i2c_regif.md
APB_I2C_REGIF -- requirements
Module: apb_i2c_regif

Interface
REQ-001 Parameter DATA_W, default 32, APB data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 8, APB address width.
REQ-003 Parameter CFG_W, default 14, width of CONFIG and TIMEOUT registers; SHALL be at most DATA_W.
REQ-004 Parameter WAIT_MAX, default 15, maximum stall cycles on a FIFO access before error completion; SHALL be at least 1.
REQ-005 Port PCLK, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port PRESET, input, 1, reset, synchronous, active-high.
REQ-007 Ports PSEL, PENABLE, PWRITE, inputs, 1 each, APB control.
REQ-008 Ports PADDR (ADDR_W) and PWDATA (DATA_W), inputs, APB address and write data.
REQ-009 Ports PRDATA (DATA_W), PREADY (1) and PSLVERR (1), outputs, APB response.
REQ-010 Ports CFG and TIMEOUT, outputs, CFG_W each, register contents to the I2C core.
REQ-011 Ports TX_DATA (DATA_W) and TX_WR_EN (1), outputs, TX FIFO push.
REQ-012 Ports RX_DATA (DATA_W) and RX_RD_EN: RX_DATA is an input, RX_RD_EN a 1-bit output; together they pop the RX FIFO.
REQ-013 Ports TX_FULL, TX_EMPTY, RX_EMPTY and I2C_ERROR, inputs, 1 each, core status.
REQ-014 Port IRQ, output, 1, combined interrupt.

Function
REQ-015 Register map (byte offsets), fixed:
- 0x00 TXDATA, W
- 0x04 RXDATA, R
- 0x08 CONFIG, RW
- 0x0C TIMEOUT, RW
- 0x10 STATUS, RO: bit0 TX_FULL, bit1 TX_EMPTY, bit2 RX_EMPTY, bit3 I2C_ERROR
- 0x14 IRQ_EN, RW, 3 bits
- 0x18 IRQ_STAT, W1C, 3 bits
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS and STALL:
- IDLE to SETUP on PSEL and not PENABLE.
- SETUP to ACCESS unconditionally.
- ACCESS or STALL to IDLE when the transfer completes; otherwise ACCESS to STALL.
REQ-017 Register accesses SHALL be zero-wait: PREADY is high in the first ACCESS cycle.
REQ-018 A TXDATA write with TX_FULL high SHALL stall, PREADY low, until TX_FULL goes low; it then completes with TX_WR_EN high for exactly that one cycle and TX_DATA equal to PWDATA.
REQ-019 An RXDATA read with RX_EMPTY high SHALL stall likewise; it then completes with RX_RD_EN high for one cycle and PRDATA equal to RX_DATA.
REQ-020 A stall counter SHALL count stall cycles; when it reaches WAIT_MAX, the transfer completes with PREADY and PSLVERR high and no FIFO strobe.
REQ-021 The following SHALL complete zero-wait with PSLVERR high and no state change:
- an unmapped or non-word-aligned address
- a write to RXDATA or STATUS
- a read of TXDATA
REQ-022 PRDATA SHALL be zero whenever PREADY is low or PSLVERR is high; register bits above CFG_W or the field width read zero.
REQ-023 CONFIG, TIMEOUT and IRQ_EN SHALL update at the end of the completing cycle from PWDATA, truncated to their width.
REQ-024 IRQ_STAT bit0 SHALL set on a TX_EMPTY rising edge, bit1 on an RX_EMPTY falling edge, and bit2 on an I2C_ERROR rising edge; edges are detected against the previous cycle's value.
REQ-025 Writing 1 to an IRQ_STAT bit SHALL clear it; a set event in the same cycle wins.
REQ-026 IRQ SHALL be the OR-reduction of IRQ_STAT AND IRQ_EN, registered-free and combinational from those flops.
REQ-027 TX_WR_EN and RX_RD_EN SHALL never be high in the same cycle, and never outside ACCESS or STALL.

Reset
REQ-028 With PRESET high at a PCLK edge, the following SHALL become zero:
- the FSM, which returns to IDLE
- the stall counter
- CFG, TIMEOUT, IRQ_EN and IRQ_STAT
- the edge-detect history flops
REQ-029 While in reset, PREADY, PSLVERR, TX_WR_EN, RX_RD_EN and IRQ SHALL be low.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no FIFO strobe; the bus master then sees PREADY low until a new transfer begins.

Structure
REQ-031 Package apb_i2c_pkg SHALL hold:
- register offset constants
- STATUS and IRQ bit indices
- the FSM state enum
REQ-032 Interrupt edge detection, IRQ_STAT and IRQ_EN SHALL live in sub-module apb_i2c_irq_ctrl; all remaining logic is in apb_i2c_regif.

Verification
REQ-033 Write 0x1ABC to 0x08, then read 0x08 -> CFG=0x1ABC, read returns 0x00001ABC, both zero-wait, PSLVERR low.
REQ-034 TX_FULL high, write 0xDEADBEEF to 0x00, release TX_FULL after 3 stall cycles -> PREADY high in 4th ACCESS/STALL cycle, one TX_WR_EN pulse with TX_DATA=0xDEADBEEF.
REQ-035 RX_EMPTY held high, read 0x04, WAIT_MAX=15 -> completion after 15 stall cycles, PSLVERR=1, PRDATA=0, no RX_RD_EN.
REQ-036 Write 0x20, then write 0x10 -> each PSLVERR=1 zero-wait; STATUS, CFG and TIMEOUT unchanged.
REQ-037 IRQ_EN=0x4; pulse I2C_ERROR -> IRQ=1; write 0x4 to 0x18 in the same cycle as a second I2C_ERROR rise -> IRQ_STAT bit2 stays 1.
REQ-038 Assert PRESET during STALL of a TXDATA write -> next cycle FSM in IDLE, no TX_WR_EN, CFG=0.
